// File: rtl/conversor_bcd_resultado_if.sv
// Handshake/bus bundle between the result producer and the BCD conversion stage.
// estado_dbg mirrors the converter FSM state for observation only.
interface conversor_bcd_resultado_if #(
  parameter int LARGURA = 16,
  parameter int DIGITOS = 5
);
  // valido is a request qualifier, not a valid/ready pair: it is sampled only
  // while the stage is idle (ocupado=0). A request seen while busy is dropped,
  // and completion is announced by a one-cycle pronto_bcd pulse.
  logic                   valido;
  logic [LARGURA-1:0]     Resultado;
  logic [4*DIGITOS-1:0]   digitos;
  logic                   negativo;
  logic                   ocupado;
  logic                   pronto_bcd;
  logic [1:0]             estado_dbg;

  modport master (
    output valido, Resultado,
    input  digitos, negativo, ocupado, pronto_bcd, estado_dbg
  );

  modport slave (
    input  valido, Resultado,
    output digitos, negativo, ocupado, pronto_bcd, estado_dbg
  );
endinterface

// File: rtl/conversor_bcd_resultado.sv
// Captures Resultado and converts it to packed BCD with a sequential shift-add-3 engine.
// Optional macro SINAL_EN: treat Resultado as two's complement and report its sign.
module conversor_bcd_resultado #(
  parameter int LARGURA = 16,
  parameter int DIGITOS = 5
) (
  input  logic                    ck,
  input  logic                    rst,
  conversor_bcd_resultado_if.slave bus
);

  localparam int CW    = $clog2(LARGURA);
  localparam int W_BCD = 4 * DIGITOS;
  localparam logic [CW-1:0] CONT_ULT = CW'(LARGURA - 1);
  localparam logic [CW-1:0] CONT_UM  = CW'(1);

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    CONVERTE  = 2'd1,
    CONCLUIDO = 2'd2
  } estado_t;

  estado_t              estado_q,   estado_d;
  logic [LARGURA-1:0]   desl_q,     desl_d;
  logic [W_BCD-1:0]     bcd_q,      bcd_d;
  logic [CW-1:0]        cont_q,     cont_d;
  logic [W_BCD-1:0]     digitos_q,  digitos_d;
  logic                 negativo_q, negativo_d;
  logic                 sinal_q,    sinal_d;
  logic                 ocupado_q,  ocupado_d;
  logic                 pronto_q,   pronto_d;

  logic [LARGURA-1:0]   magnitude;
  logic                 sinal_ent;
  logic [W_BCD-1:0]     bcd_adj;
  logic [W_BCD-1:0]     bcd_sh;
  logic [LARGURA-1:0]   desl_sh;

`ifdef SINAL_EN
  // Negating 16'h8000 yields 16'h8000 again, which read as unsigned is 32768.
  always_comb begin
    sinal_ent = bus.Resultado[LARGURA-1];
    if (bus.Resultado[LARGURA-1])
      magnitude = (~bus.Resultado) + {{(LARGURA-1){1'b0}}, 1'b1};
    else
      magnitude = bus.Resultado;
  end
`else
  always_comb begin
    sinal_ent = 1'b0;
    magnitude = bus.Resultado;
  end
`endif

  // One double-dabble step: correct every nibble >= 5, then shift {bcd,desl} left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITOS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    {bcd_sh, desl_sh} = {bcd_adj[W_BCD-2:0], desl_q, 1'b0};
  end

  always_comb begin
    estado_d   = estado_q;
    desl_d     = desl_q;
    bcd_d      = bcd_q;
    cont_d     = cont_q;
    digitos_d  = digitos_q;
    negativo_d = negativo_q;
    sinal_d    = sinal_q;
    ocupado_d  = ocupado_q;
    pronto_d   = 1'b0;

    case (estado_q)
      OCIOSO: begin
        if (bus.valido) begin
          desl_d    = magnitude;
          bcd_d     = '0;
          cont_d    = '0;
          sinal_d   = sinal_ent;
          ocupado_d = 1'b1;
          estado_d  = CONVERTE;
        end
      end
      CONVERTE: begin
        desl_d = desl_sh;
        bcd_d  = bcd_sh;
        cont_d = cont_q + CONT_UM;
        if (cont_q == CONT_ULT) begin
          digitos_d  = bcd_sh;
          negativo_d = sinal_q;
          pronto_d   = 1'b1;
          estado_d   = CONCLUIDO;
        end
      end
      CONCLUIDO: begin
        ocupado_d = 1'b0;
        estado_d  = OCIOSO;
      end
      default: begin
        ocupado_d = 1'b0;
        estado_d  = OCIOSO;
      end
    endcase
  end

  // Reset also aborts a conversion in flight without announcing it.
  always_ff @(posedge ck) begin
    if (rst) begin
      estado_q   <= OCIOSO;
      desl_q     <= '0;
      bcd_q      <= '0;
      cont_q     <= '0;
      digitos_q  <= '0;
      negativo_q <= 1'b0;
      sinal_q    <= 1'b0;
      ocupado_q  <= 1'b0;
      pronto_q   <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      desl_q     <= desl_d;
      bcd_q      <= bcd_d;
      cont_q     <= cont_d;
      digitos_q  <= digitos_d;
      negativo_q <= negativo_d;
      sinal_q    <= sinal_d;
      ocupado_q  <= ocupado_d;
      pronto_q   <= pronto_d;
    end
  end

  assign bus.digitos    = digitos_q;
  assign bus.negativo   = negativo_q;
  assign bus.ocupado    = ocupado_q;
  assign bus.pronto_bcd = pronto_q;
  assign bus.estado_dbg = estado_q;

endmodule

// File: tb/tb_conversor_bcd_resultado.sv
// Scoreboard bench for conversor_bcd_resultado: directed values with hand-computed BCD.
// Expected values follow the SINAL_EN build selection.
module tb_conversor_bcd_resultado;

  logic ck;
  logic rst;

  conversor_bcd_resultado_if #(.LARGURA(16), .DIGITOS(5)) bus ();

  conversor_bcd_resultado #(.LARGURA(16), .DIGITOS(5)) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial ck = 1'b0;
  always #5 ck = ~ck;

  // ---------------- scoreboard ----------------
  logic [20:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int pronto_cnt = 0;

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_cmp++;
    if (atual !== esperado) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nome, atual, esperado);
    end
  endtask

  // Monitor: every completion pulse pops one expected {negativo, digitos}.
  always @(negedge ck) begin
    logic [20:0] e;
    if (!rst && bus.pronto_bcd === 1'b1) begin
      pronto_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_pronto", 32'(bus.digitos), 32'hFFFFFFFF);
      end else begin
        e = exp_q.pop_front();
        check("digitos", 32'(bus.digitos), 32'(e[19:0]));
        check("negativo", 32'(bus.negativo), 32'(e[20]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic converte(input logic [15:0] v, input logic push,
                          input logic [19:0] exp_d, input logic exp_n,
                          input logic medir);
    int lat;
    int ocup;
    @(negedge ck);
    bus.valido    = 1'b1;
    bus.Resultado = v;
    if (push) exp_q.push_back({exp_n, exp_d});
    @(posedge ck);
    #1;
    bus.valido    = 1'b0;
    bus.Resultado = 16'hA5A5;
    if (medir) begin
      lat  = 0;
      ocup = bus.ocupado ? 1 : 0;
      for (int k = 1; k <= 40; k++) begin
        @(posedge ck);
        #1;
        if (bus.ocupado) ocup++;
        if (bus.pronto_bcd && lat == 0) lat = k;
        if (!bus.ocupado) break;
      end
      check("latencia", 32'(lat), 32'd16);
      check("ocupado_ciclos", 32'(ocup), 32'd17);
    end
  endtask

  task automatic espera_ocioso();
    int k;
    k = 0;
    while (bus.ocupado === 1'b1 && k < 40) begin
      @(posedge ck);
      #1;
      k++;
    end
    check("timeout_ocioso", 32'(bus.ocupado), 32'd0);
    @(posedge ck);
    #1;
  endtask

  // ---------------- stimulus ----------------
`ifdef SINAL_EN
  localparam logic [19:0] EXP_FFFF = 20'h00001;
  localparam logic        NEG_FFFF = 1'b1;
  localparam logic [19:0] EXP_FFF2 = 20'h00014;
  localparam logic        NEG_FFF2 = 1'b1;
  localparam logic        NEG_8000 = 1'b1;
`else
  localparam logic [19:0] EXP_FFFF = 20'h65535;
  localparam logic        NEG_FFFF = 1'b0;
  localparam logic [19:0] EXP_FFF2 = 20'h65522;
  localparam logic        NEG_FFF2 = 1'b0;
  localparam logic        NEG_8000 = 1'b0;
`endif

  initial begin
    int pc;
    rst           = 1'b1;
    bus.valido    = 1'b0;
    bus.Resultado = 16'h0000;
    repeat (3) @(posedge ck);
    #1;
    rst = 1'b0;
    @(posedge ck);
    #1;
    check("reset_digitos",  32'(bus.digitos),    32'd0);
    check("reset_negativo", 32'(bus.negativo),   32'd0);
    check("reset_ocupado",  32'(bus.ocupado),    32'd0);
    check("reset_pronto",   32'(bus.pronto_bcd), 32'd0);

    // zero, then a polynomial result, both with latency/busy measurement
    converte(16'd0, 1'b1, 20'h00000, 1'b0, 1'b1);
    espera_ocioso();
    converte(16'd14, 1'b1, 20'h00014, 1'b0, 1'b1);
    espera_ocioso();

    // full-range value
    converte(16'hFFFF, 1'b1, EXP_FFFF, NEG_FFFF, 1'b0);
    espera_ocioso();

    // request while busy must be dropped
    pc = pronto_cnt;
    converte(16'd1234, 1'b1, 20'h01234, 1'b0, 1'b0);
    repeat (4) @(posedge ck);
    @(negedge ck);
    bus.valido    = 1'b1;
    bus.Resultado = 16'd9999;
    @(posedge ck);
    #1;
    bus.valido = 1'b0;
    espera_ocioso();
    check("pulsos_ocupado", 32'(pronto_cnt - pc), 32'd1);

    // idle with valido low keeps the last result
    repeat (5) @(posedge ck);
    #1;
    check("retencao", 32'(bus.digitos), 32'h01234);

    // reset in the middle of a conversion
    pc = pronto_cnt;
    converte(16'd500, 1'b0, 20'h00000, 1'b0, 1'b0);
    repeat (7) @(posedge ck);
    @(negedge ck);
    rst = 1'b1;
    @(posedge ck);
    #1;
    check("abort_digitos", 32'(bus.digitos),    32'd0);
    check("abort_ocupado", 32'(bus.ocupado),    32'd0);
    check("abort_pronto",  32'(bus.pronto_bcd), 32'd0);
    @(negedge ck);
    rst = 1'b0;
    repeat (20) @(posedge ck);
    #1;
    check("abort_sem_pulso", 32'(pronto_cnt - pc), 32'd0);
    converte(16'd42, 1'b1, 20'h00042, 1'b0, 1'b0);
    espera_ocioso();

    // sign boundaries
    converte(16'hFFF2, 1'b1, EXP_FFF2, NEG_FFF2, 1'b0);
    espera_ocioso();
    converte(16'h8000, 1'b1, 20'h32768, NEG_8000, 1'b0);
    espera_ocioso();
    converte(16'h7FFF, 1'b1, 20'h32767, 1'b0, 1'b0);
    espera_ocioso();
    converte(16'd9, 1'b1, 20'h00009, 1'b0, 1'b0);
    espera_ocioso();

    repeat (3) @(posedge ck);
    check("fila_vazia", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
